uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the received character width.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two), SHALL set the receive buffer depth.
REQ-003 Parameter PRESCALE_W, default 6, SHALL set the prescale field width.
REQ-004 clk  in  1  single clock; all logic SHALL run on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 ctrl_en  in  1  receiver enable from host.
REQ-007 cfg_wr  in  1  one-cycle config write strobe; cfg_prescale in PRESCALE_W, cfg_par_en in 1, cfg_par_typ in 1.
REQ-008 rx_busy  in  1  receiver core frame-in-progress flag.
REQ-009 rx_data_valid  in  1  one-cycle frame-complete pulse; rx_p_data  in  DATA_WIDTH.
REQ-010 rx_par_err, rx_stp_err  in  1  one-cycle error pulses from the core.
REQ-011 Prescale  out  PRESCALE_W, PAR_EN  out  1, PAR_TYP  out  1: active config to the core.
REQ-012 rx_en  out  1  core run gate.
REQ-013 rd_valid  out  1, rd_data  out  DATA_WIDTH, rd_ready  in  1: host read handshake.
REQ-014 cfg_pending  out  1, cfg_err  out  1 (pulse), overrun  out  1 (sticky), err_cnt  out  8, clr_status  in  1.

Function
REQ-015 FSM states SHALL be OFF, IDLE, BUSY, APPLY; rx_en SHALL be 1 only in IDLE and BUSY.
REQ-016 OFF->IDLE when ctrl_en=1 and cfg_pending=0; OFF->APPLY when ctrl_en=1 and cfg_pending=1.
REQ-017 IDLE->BUSY when rx_busy=1; IDLE->APPLY when rx_busy=0 and cfg_pending=1; rx_busy has priority.
REQ-018 BUSY->IDLE when rx_busy=0; config SHALL never change while in BUSY.
REQ-019 APPLY SHALL last exactly one cycle, copy the shadow config to the active config, clear cfg_pending, then go to IDLE.
REQ-020 Any state SHALL go to OFF on the next edge when ctrl_en=0; this aborts a frame in BUSY, and a frame-complete pulse already in flight is still buffered.
REQ-021 cfg_wr with cfg_prescale in {8,16,32} SHALL load the shadow config and set cfg_pending; a second write before APPLY SHALL overwrite it (last wins).
REQ-022 cfg_wr with any other prescale SHALL pulse cfg_err for one cycle and leave the shadow config and cfg_pending unchanged.
REQ-023 Buffer SHALL be first-word-fallthrough: rd_valid=!empty, rd_data=head entry, and rd_valid rises one cycle after an rx_data_valid into an empty buffer.
REQ-024 Pop SHALL occur when rd_valid and rd_ready are both 1; rd_data SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-025 Push SHALL occur on rx_data_valid when not full; when full without a same-cycle pop, the data SHALL be dropped and overrun set.
REQ-026 Simultaneous push and pop when full SHALL accept both, leave the count unchanged, and not set overrun.
REQ-027 Each cycle with rx_par_err|rx_stp_err SHALL increment err_cnt by exactly one, saturating at 255; errored frames SHALL NOT be pushed.
REQ-028 clr_status SHALL clear overrun and err_cnt; a same-cycle set or increment SHALL win over the clear.

Reset
REQ-029 On rst: state=OFF, rx_en=0, Prescale=8, PAR_EN=0, PAR_TYP=0, shadow config equal to the active config, cfg_pending=0, cfg_err=0, buffer empty (rd_valid=0, rd_data=0), overrun=0, err_cnt=0.
REQ-030 rst SHALL override all other inputs in the same cycle, including mid-frame and with a pending config.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state encoding, the legal prescale constants (8/16/32), and the default widths.
REQ-032 The buffer SHALL be the sub-module uart_sync_fifo (parameterised width and depth, full/empty/count outputs); the FSM, config and status logic stay in uart_rx_ctrl.

Verification
REQ-033 rst, ctrl_en=1, cfg_wr prescale=16 par_en=1 -> APPLY for one cycle, rx_en=0 for that cycle, then Prescale=16, PAR_EN=1, cfg_pending=0.
REQ-034 rx_busy=1 then cfg_wr prescale=32 -> Prescale holds at its old value until rx_busy falls, then APPLY and Prescale=32.
REQ-035 cfg_wr prescale=12 -> cfg_err pulses once; Prescale and cfg_pending unchanged.
REQ-036 Five rx_data_valid pulses 0xA1..0xA5 with rd_ready=0 -> 0xA5 dropped, overrun=1; draining yields 0xA1..0xA4 in order.
REQ-037 Full buffer with rx_data_valid and rd_ready=1 in the same cycle -> count stays 4, overrun=0.
REQ-038 300 rx_stp_err pulses -> err_cnt=255; clr_status -> err_cnt=0, overrun=0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants for the UART receive controller.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    localparam int c_DATA_WIDTH = 8;
    localparam int c_FIFO_DEPTH = 4;
    localparam int c_PRESCALE_W = 6;

    localparam int c_PRESCALE_8  = 8;
    localparam int c_PRESCALE_16 = 16;
    localparam int c_PRESCALE_32 = 32;

    localparam logic [1:0] c_ST_OFF   = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_BUSY  = 2'd2;
    localparam logic [1:0] c_ST_APPLY = 2'd3;

    function automatic logic f_prescale_legal(input logic [31:0] p);
        return (p == 32'(c_PRESCALE_8)) || (p == 32'(c_PRESCALE_16)) ||
               (p == 32'(c_PRESCALE_32));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_sync_fifo
// Brief   : Single-clock first-word-fallthrough FIFO; DEPTH must be a power of two.
// Revision: 1.0
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    // Head is masked while empty so the read port idles at zero.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : UART receiver control: run FSM, safe config apply, RX buffer, status.
// Revision: 1.0
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int FIFO_DEPTH = c_FIFO_DEPTH,
    parameter int PRESCALE_W = c_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_en,
    input  logic                  cfg_wr,
    input  logic [PRESCALE_W-1:0] cfg_prescale,
    input  logic                  cfg_par_en,
    input  logic                  cfg_par_typ,
    input  logic                  rx_busy,
    input  logic                  rx_data_valid,
    input  logic [DATA_WIDTH-1:0] rx_p_data,
    input  logic                  rx_par_err,
    input  logic                  rx_stp_err,
    output logic [PRESCALE_W-1:0] Prescale,
    output logic                  PAR_EN,
    output logic                  PAR_TYP,
    output logic                  rx_en,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  cfg_pending,
    output logic                  cfg_err,
    output logic                  overrun,
    output logic [7:0]            err_cnt,
    input  logic                  clr_status
);

    localparam logic [PRESCALE_W-1:0] c_PRESCALE_RST = PRESCALE_W'(c_PRESCALE_8);

    logic [1:0]            r_state;
    logic                  r_rx_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [PRESCALE_W-1:0] r_sh_prescale;
    logic                  r_sh_par_en;
    logic                  r_sh_par_typ;
    logic                  r_cfg_pending;
    logic                  r_cfg_err;
    logic                  r_overrun;
    logic [7:0]            r_err_cnt;

    logic                  w_cfg_legal;
    logic                  w_apply;
    logic                  w_err;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_unused_count;

    assign w_cfg_legal = f_prescale_legal(32'(cfg_prescale));
    assign w_apply     = (r_state == c_ST_APPLY);
    assign w_err       = rx_par_err || rx_stp_err;
    assign w_push      = rx_data_valid && !w_err;
    assign w_pop       = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_OFF;
            r_rx_en    <= 1'b0;
            r_prescale <= c_PRESCALE_RST;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
        end else begin
            if (w_apply) begin
                r_prescale <= r_sh_prescale;
                r_par_en   <= r_sh_par_en;
                r_par_typ  <= r_sh_par_typ;
            end
            if (!ctrl_en) begin
                r_state <= c_ST_OFF;
                r_rx_en <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_OFF: begin
                        r_state <= r_cfg_pending ? c_ST_APPLY : c_ST_IDLE;
                        r_rx_en <= !r_cfg_pending;
                    end
                    c_ST_IDLE: begin
                        if (rx_busy) begin
                            r_state <= c_ST_BUSY;
                            r_rx_en <= 1'b1;
                        end else if (r_cfg_pending) begin
                            r_state <= c_ST_APPLY;
                            r_rx_en <= 1'b0;
                        end
                    end
                    c_ST_BUSY: begin
                        if (!rx_busy) begin
                            r_state <= c_ST_IDLE;
                        end
                        r_rx_en <= 1'b1;
                    end
                    c_ST_APPLY: begin
                        r_state <= c_ST_IDLE;
                        r_rx_en <= 1'b1;
                    end
                    default: begin
                        r_state <= c_ST_OFF;
                        r_rx_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A write landing in the APPLY cycle stays pending and is applied on the next pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_prescale <= c_PRESCALE_RST;
            r_sh_par_en   <= 1'b0;
            r_sh_par_typ  <= 1'b0;
            r_cfg_pending <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_cfg_err <= cfg_wr && !w_cfg_legal;
            if (cfg_wr && w_cfg_legal) begin
                r_sh_prescale <= cfg_prescale;
                r_sh_par_en   <= cfg_par_en;
                r_sh_par_typ  <= cfg_par_typ;
                r_cfg_pending <= 1'b1;
            end else if (w_apply) begin
                r_cfg_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else if (clr_status) begin
                r_overrun <= 1'b0;
            end
            if (w_err) begin
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (clr_status) begin
                r_err_cnt <= 8'd0;
            end
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (rx_p_data),
        .i_rd_en   (w_pop),
        .o_rd_data (rd_data),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_unused_count)
    );

    assign rd_valid    = !w_empty;
    assign Prescale    = r_prescale;
    assign PAR_EN      = r_par_en;
    assign PAR_TYP     = r_par_typ;
    assign rx_en       = r_rx_en;
    assign cfg_pending = r_cfg_pending;
    assign cfg_err     = r_cfg_err;
    assign overrun     = r_overrun;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Self-checking bench for uart_rx_ctrl with a queue-based buffer model.
// Revision: 1.0
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctrl_en;
    logic          cfg_wr;
    logic [PW-1:0] cfg_prescale;
    logic          cfg_par_en;
    logic          cfg_par_typ;
    logic          rx_busy;
    logic          rx_data_valid;
    logic [DW-1:0] rx_p_data;
    logic          rx_par_err;
    logic          rx_stp_err;
    logic [PW-1:0] Prescale;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic          rx_en;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          cfg_pending;
    logic          cfg_err;
    logic          overrun;
    logic [7:0]    err_cnt;
    logic          clr_status;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_ctrl #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .PRESCALE_W (PW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ctrl_en       (ctrl_en),
        .cfg_wr        (cfg_wr),
        .cfg_prescale  (cfg_prescale),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_typ   (cfg_par_typ),
        .rx_busy       (rx_busy),
        .rx_data_valid (rx_data_valid),
        .rx_p_data     (rx_p_data),
        .rx_par_err    (rx_par_err),
        .rx_stp_err    (rx_stp_err),
        .Prescale      (Prescale),
        .PAR_EN        (PAR_EN),
        .PAR_TYP       (PAR_TYP),
        .rx_en         (rx_en),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .cfg_pending   (cfg_pending),
        .cfg_err       (cfg_err),
        .overrun       (overrun),
        .err_cnt       (err_cnt),
        .clr_status    (clr_status)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cfg_wr = 0; cfg_prescale = 0; cfg_par_en = 0; cfg_par_typ = 0;
        rx_busy = 0; rx_data_valid = 0; rx_p_data = 0; rx_par_err = 0;
        rx_stp_err = 0; rd_ready = 0; clr_status = 0;
    endtask

    task automatic write_cfg(input int p, input logic en, input logic typ);
        cfg_wr = 1; cfg_prescale = PW'(p); cfg_par_en = en; cfg_par_typ = typ;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; ctrl_en = 1; write_cfg(16, 1, 1);
        rx_data_valid = 1; rx_p_data = 8'h3C; rx_stp_err = 0; rd_ready = 0;
        tick(); tick();
        n_vec++; if (rx_en !== 1'b0) begin n_err++; $display("FAIL reset_rx_en: got %0b required 0", rx_en); end
        n_vec++; if (Prescale !== 6'd8) begin n_err++; $display("FAIL reset_prescale: got %0d required 8", Prescale); end
        n_vec++; if ({PAR_EN, PAR_TYP} !== 2'b00) begin n_err++; $display("FAIL reset_par: got %b required 00", {PAR_EN, PAR_TYP}); end
        n_vec++; if ({cfg_pending, cfg_err} !== 2'b00) begin n_err++; $display("FAIL reset_cfg_flags: got %b required 00", {cfg_pending, cfg_err}); end
        n_vec++; if ({rd_valid, rd_data} !== 9'h0) begin n_err++; $display("FAIL reset_buffer: got %0b/%0h required 0/0", rd_valid, rd_data); end
        n_vec++; if ({overrun, err_cnt} !== 9'h0) begin n_err++; $display("FAIL reset_status: got %0b/%0d required 0/0", overrun, err_cnt); end
        rst = 0; ctrl_en = 0; idle_inputs();
        tick();
    endtask

    task automatic test_cfg_apply();
        ctrl_en = 1; write_cfg(16, 1, 0);
        tick();
        cfg_wr = 0;
        n_vec++; if (cfg_pending !== 1'b1 || Prescale !== 6'd8) begin n_err++; $display("FAIL apply_pending: got %0b/%0d required 1/8", cfg_pending, Prescale); end
        tick();
        n_vec++; if (rx_en !== 1'b0 || Prescale !== 6'd8) begin n_err++; $display("FAIL apply_cycle: got rx_en %0b pre %0d required 0/8", rx_en, Prescale); end
        tick();
        n_vec++; if ({rx_en, Prescale, PAR_EN, PAR_TYP, cfg_pending} !== {1'b1, 6'd16, 1'b1, 1'b0, 1'b0})
            begin n_err++; $display("FAIL apply_done: got en %0b pre %0d pe %0b pt %0b pend %0b required 1/16/1/0/0", rx_en, Prescale, PAR_EN, PAR_TYP, cfg_pending); end
    endtask

    task automatic test_cfg_busy();
        int hold;
        rx_busy = 1;
        tick();
        write_cfg(32, 0, 1);
        tick();
        cfg_wr = 0;
        hold = $urandom_range(3, 6);
        for (int i = 0; i < hold; i++) begin
            tick();
            n_vec++; if (Prescale !== 6'd16 || rx_en !== 1'b1) begin n_err++; $display("FAIL busy_hold: got pre %0d en %0b required 16/1", Prescale, rx_en); end
        end
        rx_busy = 0;
        tick();
        n_vec++; if (Prescale !== 6'd16 || rx_en !== 1'b1) begin n_err++; $display("FAIL busy_exit: got pre %0d en %0b required 16/1", Prescale, rx_en); end
        tick();
        n_vec++; if (rx_en !== 1'b0) begin n_err++; $display("FAIL busy_apply: got en %0b required 0", rx_en); end
        tick();
        n_vec++; if ({Prescale, PAR_EN, PAR_TYP, rx_en} !== {6'd32, 1'b0, 1'b1, 1'b1})
            begin n_err++; $display("FAIL busy_applied: got pre %0d pe %0b pt %0b en %0b required 32/0/1/1", Prescale, PAR_EN, PAR_TYP, rx_en); end
    endtask

    task automatic test_cfg_err();
        int p;
        for (int i = 0; i < 5; i++) begin
            if (i == 0) p = 12;
            else begin
                do p = $urandom_range(0, 63); while (p == 8 || p == 16 || p == 32);
            end
            write_cfg(p, 1, 0);
            tick();
            cfg_wr = 0;
            n_vec++; if ({cfg_err, cfg_pending, Prescale} !== {1'b1, 1'b0, 6'd32})
                begin n_err++; $display("FAIL cfg_err_pulse p=%0d: got err %0b pend %0b pre %0d required 1/0/32", p, cfg_err, cfg_pending, Prescale); end
            tick();
            n_vec++; if (cfg_err !== 1'b0 || rx_en !== 1'b1) begin n_err++; $display("FAIL cfg_err_clear: got err %0b en %0b required 0/1", cfg_err, rx_en); end
        end
        // Last legal write wins; an illegal write after it leaves the shadow intact.
        rx_busy = 1;
        tick();
        write_cfg(16, 1, 1); tick();
        write_cfg(8, 0, 1);  tick();
        write_cfg(12, 1, 0); tick();
        cfg_wr = 0;
        n_vec++; if ({cfg_err, cfg_pending, Prescale} !== {1'b1, 1'b1, 6'd32})
            begin n_err++; $display("FAIL lastwins_err: got err %0b pend %0b pre %0d required 1/1/32", cfg_err, cfg_pending, Prescale); end
        rx_busy = 0;
        tick(); tick(); tick();
        n_vec++; if ({Prescale, PAR_EN, PAR_TYP, cfg_pending} !== {6'd8, 1'b0, 1'b1, 1'b0})
            begin n_err++; $display("FAIL lastwins_apply: got pre %0d pe %0b pt %0b pend %0b required 8/0/1/0", Prescale, PAR_EN, PAR_TYP, cfg_pending); end
    endtask

    task automatic test_overrun();
        rd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            rx_data_valid = 1; rx_p_data = DW'(8'hA1 + i);
            tick();
            if (i == 0) begin
                n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'hA1) begin n_err++; $display("FAIL fwft_first: got %0b/%0h required 1/a1", rd_valid, rd_data); end
            end
            if (i == 3) begin
                n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_early: got %0b required 0", overrun); end
            end
        end
        rx_data_valid = 0;
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %0b required 1", overrun); end
        tick(); tick();
        n_vec++; if (rd_data !== 8'hA1) begin n_err++; $display("FAIL rd_stable: got %0h required a1", rd_data); end
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== DW'(8'hA1 + i))
                begin n_err++; $display("FAIL drain_%0d: got %0b/%0h required 1/%0h", i, rd_valid, rd_data, 8'hA1 + i); end
            tick();
        end
        rd_ready = 0;
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %0b required 0", rd_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp_q[$];
        clr_status = 1; tick(); clr_status = 0;
        n_vec++; if (overrun !== 1'b0) begin n_err++; $display("FAIL clr_ovr: got %0b required 0", overrun); end
        for (int i = 0; i < 4; i++) begin
            rx_data_valid = 1; rx_p_data = DW'(8'hB0 + i); tick();
        end
        rx_data_valid = 1; rx_p_data = 8'hC0; rd_ready = 1;
        tick();
        n_vec++; if (overrun !== 1'b0 || rd_data !== 8'hB1) begin n_err++; $display("FAIL full_pushpop: got ovr %0b data %0h required 0/b1", overrun, rd_data); end
        rx_p_data = 8'hD0; rd_ready = 0;
        tick();
        rx_data_valid = 0;
        n_vec++; if (overrun !== 1'b1) begin n_err++; $display("FAIL still_full: got ovr %0b required 1", overrun); end
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hC0};
        rd_ready = 1;
        foreach (exp_q[i]) begin
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== exp_q[i]) begin n_err++; $display("FAIL full_drain_%0d: got %0b/%0h required 1/%0h", i, rd_valid, rd_data, exp_q[i]); end
            tick();
        end
        rd_ready = 0;
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL full_drain_empty: got %0b required 0", rd_valid); end
    endtask

    task automatic test_err_cnt();
        int model = 0;
        for (int i = 0; i < 300; i++) begin
            rx_stp_err = 1; rx_par_err = 1'($urandom);
            rx_data_valid = 1'($urandom); rx_p_data = DW'($urandom);
            tick();
            model = (model < 255) ? model + 1 : 255;
            if (i == 0 || i == 99 || i == 254 || i == 255 || i == 299) begin
                n_vec++; if (err_cnt !== 8'(model)) begin n_err++; $display("FAIL err_cnt_%0d: got %0d required %0d", i, err_cnt, model); end
            end
        end
        rx_stp_err = 0; rx_par_err = 0; rx_data_valid = 0;
        n_vec++; if (rd_valid !== 1'b0 || overrun !== 1'b1) begin n_err++; $display("FAIL err_no_push: got rv %0b ovr %0b required 0/1", rd_valid, overrun); end
        clr_status = 1; tick(); clr_status = 0;
        n_vec++; if (err_cnt !== 8'd0 || overrun !== 1'b0) begin n_err++; $display("FAIL clr_status: got cnt %0d ovr %0b required 0/0", err_cnt, overrun); end
    endtask

    task automatic test_disable();
        rx_busy = 1; tick();
        ctrl_en = 0; rx_data_valid = 1; rx_p_data = 8'h5A;
        tick();
        rx_data_valid = 0; rx_busy = 0;
        n_vec++; if ({rx_en, rd_valid, rd_data} !== {1'b0, 1'b1, 8'h5A}) begin n_err++; $display("FAIL abort_frame: got en %0b rv %0b data %0h required 0/1/5a", rx_en, rd_valid, rd_data); end
        rd_ready = 1; tick(); rd_ready = 0;
        write_cfg(16, 1, 0); tick(); cfg_wr = 0;
        tick();
        n_vec++; if (cfg_pending !== 1'b1 || rx_en !== 1'b0) begin n_err++; $display("FAIL off_pending: got pend %0b en %0b required 1/0", cfg_pending, rx_en); end
        ctrl_en = 1; tick();
        n_vec++; if (rx_en !== 1'b0 || Prescale !== 6'd8) begin n_err++; $display("FAIL off_apply: got en %0b pre %0d required 0/8", rx_en, Prescale); end
        tick();
        n_vec++; if ({rx_en, Prescale, PAR_EN, PAR_TYP, cfg_pending} !== {1'b1, 6'd16, 1'b1, 1'b0, 1'b0})
            begin n_err++; $display("FAIL off_applied: got en %0b pre %0d pe %0b pt %0b pend %0b required 1/16/1/0/0", rx_en, Prescale, PAR_EN, PAR_TYP, cfg_pending); end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic          m_ovr = 0;
        int            m_cnt = 0;
        logic          pop, push, err;
        for (int c = 0; c < 400; c++) begin
            n_vec++; if (rd_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rnd_valid c=%0d: got %0b required %0b", c, rd_valid, q.size() != 0); end
            n_vec++; if (rd_data !== ((q.size() != 0) ? q[0] : DW'(0))) begin n_err++; $display("FAIL rnd_data c=%0d: got %0h required %0h", c, rd_data, (q.size() != 0) ? q[0] : DW'(0)); end
            n_vec++; if (overrun !== m_ovr) begin n_err++; $display("FAIL rnd_ovr c=%0d: got %0b required %0b", c, overrun, m_ovr); end
            n_vec++; if (err_cnt !== 8'(m_cnt)) begin n_err++; $display("FAIL rnd_cnt c=%0d: got %0d required %0d", c, err_cnt, m_cnt); end
            rx_data_valid = ($urandom_range(0, 9) < 6);
            rx_p_data     = DW'($urandom);
            rd_ready      = ($urandom_range(0, 9) < 4);
            rx_par_err    = ($urandom_range(0, 19) == 0);
            rx_stp_err    = ($urandom_range(0, 19) == 0);
            err           = rx_par_err || rx_stp_err;
            clr_status    = !err && !rx_data_valid && ($urandom_range(0, 9) == 0);
            pop  = (q.size() != 0) && rd_ready;
            push = rx_data_valid && !err;
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() < DEPTH) q.push_back(rx_p_data);
                else m_ovr = 1;
            end else if (clr_status) m_ovr = 0;
            if (err) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            else if (clr_status) m_cnt = 0;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_override();
        rx_busy = 1; tick();
        write_cfg(32, 1, 1); rx_data_valid = 1; rx_p_data = 8'h77; tick();
        cfg_wr = 0; rx_data_valid = 0;
        rst = 1; write_cfg(16, 1, 1); rx_data_valid = 1; rx_stp_err = 1; rd_ready = 1;
        tick();
        n_vec++; if ({rx_en, Prescale, PAR_EN, PAR_TYP, cfg_pending, rd_valid, err_cnt} !== {1'b0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0})
            begin n_err++; $display("FAIL rst_override: got en %0b pre %0d pe %0b pt %0b pend %0b rv %0b cnt %0d required 0/8/0/0/0/0/0", rx_en, Prescale, PAR_EN, PAR_TYP, cfg_pending, rd_valid, err_cnt); end
        rst = 0; ctrl_en = 0; idle_inputs();
        tick();
        n_vec++; if ({rx_en, cfg_pending, rd_valid, Prescale} !== {1'b0, 1'b0, 1'b0, 6'd8})
            begin n_err++; $display("FAIL rst_after: got en %0b pend %0b rv %0b pre %0d required 0/0/0/8", rx_en, cfg_pending, rd_valid, Prescale); end
    endtask

    initial begin
        rst = 1; ctrl_en = 0; idle_inputs();
        test_reset();
        test_cfg_apply();
        test_cfg_busy();
        test_cfg_err();
        test_overrun();
        test_full_push_pop();
        test_err_cnt();
        test_disable();
        test_random();
        test_reset_override();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
